// File: rtl/gf180mcu_osu_sc_9t_inv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_osu_sc_9t_inv_pipe_pkg
// Brief   : Mode encodings and the polarity transform for the 9T inverter pipe
// Revision: 1.0 - initial release
// ============================================================================
package gf180mcu_osu_sc_9t_inv_pipe_pkg;

  // Runtime polarity mode; 2'b11 is reserved and behaves as pass-through.
  typedef enum logic [1:0] {
    MODE_PASS       = 2'b00,
    MODE_INV_ALL    = 2'b01,
    MODE_INV_MASKED = 2'b10,
    MODE_RSVD       = 2'b11
  } mode_e;

  // Transform of one bit position; the caller applies it across the word
  // so the function stays independent of the pipeline width.
  function automatic logic inv_xform(input logic [1:0] mode,
                                     input logic       data,
                                     input logic       mask);
    case (mode)
      MODE_INV_ALL:    return ~data;
      MODE_INV_MASKED: return data ^ mask;
      default:         return data;
    endcase
  endfunction

endpackage : gf180mcu_osu_sc_9t_inv_pipe_pkg
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_9t_inv_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_osu_sc_9t_inv_pipe_stage
// Brief   : One elastic register stage (valid + data) with advance logic
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_osu_sc_9t_inv_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_drain,
  input  logic             i_feed_valid,
  input  logic [WIDTH-1:0] i_feed_data,
  output logic             o_advance,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // The stage may take a new word when empty or when its word leaves this cycle.
  assign o_advance = !r_valid || i_drain;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Load on advance; an advance without a feed leaves a bubble and keeps old data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_advance) begin
      r_valid <= i_feed_valid;
      if (i_feed_valid) begin
        r_data <= i_feed_data;
      end
    end
  end

endmodule : gf180mcu_osu_sc_9t_inv_pipe_stage
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_9t_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_osu_sc_9t_inv_pipe
// Brief   : Registered polarity-correcting elastic pipeline (valid/ready)
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_osu_sc_9t_inv_pipe
  import gf180mcu_osu_sc_9t_inv_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
  input  logic                       CLK,
  input  logic                       RN,
  input  logic [1:0]                 MODE,
  input  logic [WIDTH-1:0]           A,
  input  logic                       A_VALID,
  output logic                       A_READY,
  output logic [WIDTH-1:0]           Y,
  output logic                       Y_VALID,
  input  logic                       Y_READY,
  output logic [$clog2(DEPTH+1)-1:0] OCC
);

  localparam int C_OCC_W = $clog2(DEPTH + 1);

  logic                   r_in_ready;
  logic                   w_accept;
  logic [WIDTH-1:0]       w_xform;
  logic [DEPTH-1:0]       w_v;
  logic [DEPTH-1:0]       w_adv;
  logic [DEPTH-1:0]       w_drain;
  logic [DEPTH-1:0]       w_feed_v;
  logic [WIDTH-1:0]       w_feed_d [DEPTH];
  logic [WIDTH-1:0]       w_d      [DEPTH];
  logic [C_OCC_W-1:0]     w_occ;

  // Input side stays closed until the first clock edge after reset release.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
    end
  end

  assign A_READY  = r_in_ready && w_adv[0];
  assign w_accept = A_VALID && A_READY;

  // Polarity transform applied once, at acceptance, using the current MODE.
  always_comb begin
    w_xform = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_xform[b] = inv_xform(MODE, A[b], INV_MASK[b]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_feed_v[i] = w_accept;
      assign w_feed_d[i] = w_xform;
    end else begin : g_body
      assign w_feed_v[i] = w_v[i-1];
      assign w_feed_d[i] = w_d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign w_drain[i] = w_v[i] && Y_READY;
    end else begin : g_mid
      assign w_drain[i] = w_v[i] && w_adv[i+1];
    end

    gf180mcu_osu_sc_9t_inv_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk        (CLK),
      .i_rst_n      (RN),
      .i_drain      (w_drain[i]),
      .i_feed_valid (w_feed_v[i]),
      .i_feed_data  (w_feed_d[i]),
      .o_advance    (w_adv[i]),
      .o_valid      (w_v[i]),
      .o_data       (w_d[i])
    );
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + C_OCC_W'(w_v[i]);
    end
  end

  assign OCC     = w_occ;
  assign Y       = w_d[DEPTH-1];
  assign Y_VALID = w_v[DEPTH-1];

endmodule : gf180mcu_osu_sc_9t_inv_pipe
`default_nettype wire
